diffusion_pipe: RTL
===================

Name: diffusion_pipe

Overview:
- Sequential, parametrised AES/Rijndael diffusion layer: ShiftRows followed by MixColumns, in both forward and inverse modes.
- Supports Rijndael block widths of 4, 6 and 8 columns.
- Uses GF(2^8) arithmetic with reduction polynomial 0x11B.
- Processes one column per cycle behind a valid/ready handshake.
- Sits between the substitution stage and the AddRoundKey stage of the round datapath. Per-transaction controls select the mode and the final-round bypass of MixColumns.

Parameters:
- NB, 4, number of state columns; legal values are 4, 6 and 8. Any other value must trip an elaboration-time error.
- SB, 8*4*NB, flattened state width in bits (derived; do not override).

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input state is presented.
- in_ready, output, 1, block can accept a state.
- in_state, input, SB, input state. Byte (r,c) sits at bits [8*(4*c+r) +: 8].
- in_inv, input, 1, selects inverse mode: InvShiftRows and InvMixColumns. Sampled at the handshake.
- in_last, input, 1, skips MixColumns (final round). Sampled at the handshake.
- out_valid, output, 1, result is available.
- out_ready, input, 1, consumer accepts the result.
- out_state, output, SB, result, using the same byte layout as in_state.
- busy, output, 1, high in MIX and DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, column counter=0, latched mode bits=0.
- Row shift offsets C[r]:
  - NB=4 or 6: {0,1,2,3}.
  - NB=8: {0,1,3,4}.
- Forward shift: s'[r][c] = s[r][(c+C[r]) mod NB].
- Inverse shift: s'[r][c] = s[r][(c-C[r]) mod NB].
- Load (handshake when in_valid && in_ready):
  - The shifted state is written into the internal state register.
  - in_inv and in_last are latched.
  - If in_last=1, next state is DONE. Otherwise next state is MIX with col=0.
- MIX, one column per cycle (column col):
  - Forward matrix row rotation {02,03,01,01}. Inverse matrix {0E,0B,0D,09}.
  - Sums are XOR. Multiplication uses repeated xtime (shift left, XOR 0x1B if bit7 was set). Results are exactly 8 bits.
  - Columns other than col are untouched.
  - col increments each cycle. After col=NB-1 is written, next state is DONE.
- DONE:
  - out_valid=1 and out_state = state register.
  - Holds stable until out_ready=1, then returns to IDLE.
  - in_ready goes high the cycle after the output handshake; there is no same-cycle reload.
- Latency from input handshake to out_valid:
  - NB+1 cycles normally.
  - 1 cycle when in_last=1.
  - Throughput is one state per latency plus one cycle.
- in_ready=1 only in IDLE. in_valid asserted while busy is ignored; the input is not consumed.
- in_state, in_inv and in_last may change freely after the handshake without affecting the result.
- out_state reflects the register contents at all times. It is only meaningful when out_valid=1.
- rst_n asserted mid-MIX or mid-DONE: immediate return to the reset values, and the partial result is discarded.
- out_ready held high continuously: DONE lasts exactly one cycle.

Test Plan:
- Shift only, forward: NB=4, in_last=1, in_inv=0, in_state bytes 0x00..0x0F at index 4c+r.
  - Required: out_valid one cycle after the handshake.
  - Required: out column 0 = 00 05 0A 0F, column 1 = 04 09 0E 03.
- Forward MixColumns, FIPS-197 vector: NB=4, in_last=0, in_inv=0, in_state with every row constant (so the shift is an identity) and column 0 = db 13 53 45.
  - Required: out column 0 = 8e 4d a1 bc.
  - Required: out_valid exactly 5 cycles after the handshake.
- Inverse mode: in_inv=1, column 0 = 8e 4d a1 bc with constant rows.
  - Required: db 13 53 45 restored.
  - Also required: a full forward-then-inverse pass on random states returns the original, for NB=4, 6 and 8.
- NB=8 offsets: shift-only pass on bytes 0x00..0x1F.
  - Required: row 2 column 0 = in[2][3] = 0x0E.
  - Required: row 3 column 0 = in[3][4] = 0x13.
  - Required: every row's inverse pass restores the input.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE.
  - Required: out_state stable and in_ready=0 throughout.
  - Required: an in_valid pulse during this time is not consumed.
  - Required: after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n during MIX at col=2.
  - Required: out_valid=0, in_ready=1, out_state=0 immediately, with no clock edge needed.
  - Required: after release, a new transaction completes with the correct result.

Source files
------------

// File: rtl/diffusion_pipe.sv
// Rijndael diffusion layer (ShiftRows then MixColumns, forward or inverse),
// one MixColumns column per cycle behind valid/ready handshakes.
module diffusion_pipe #(
  parameter int NB = 4,
  parameter int SB = 8 * 4 * NB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SB-1:0] in_state,
  input  logic          in_inv,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SB-1:0] out_state,
  output logic          busy
);

  localparam int CW = (NB > 4) ? 3 : 2;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("diffusion_pipe: NB must be 4, 6 or 8");
  end
  if (SB != 32 * NB) begin : g_bad_sb
    $error("diffusion_pipe: SB is derived from NB and must not be overridden");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          fsm_q, fsm_d;
  logic [SB-1:0]   st_q, st_d;
  logic [CW-1:0]   col_q, col_d;
  logic            inv_q, inv_d;
  logic            last_q, last_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // NB=8 uses the wider offsets {0,1,3,4}; 4 and 6 use {0,1,2,3}.
  function automatic logic [SB-1:0] shift_rows(input logic [SB-1:0] s, input logic inv);
    logic [SB-1:0] o;
    int off;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = (NB == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < NB; c++) begin
        src = inv ? (c + NB - off) % NB : (c + off) % NB;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [31:0] o;
    logic [3:0]  k0, k1, k2, k3;
    k0 = inv ? 4'hE : 4'h2;
    k1 = inv ? 4'hB : 4'h3;
    k2 = inv ? 4'hD : 4'h1;
    k3 = inv ? 4'h9 : 4'h1;
    o  = 32'h0;
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = gmul(a[8*r +: 8], k0) ^ gmul(a[8*((r+1)%4) +: 8], k1) ^
                    gmul(a[8*((r+2)%4) +: 8], k2) ^ gmul(a[8*((r+3)%4) +: 8], k3);
    end
    return o;
  endfunction

  // Next-state: load shifted state, mix one column per cycle, hold result.
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    col_d  = col_q;
    inv_d  = inv_q;
    last_d = last_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d   = shift_rows(in_state, in_inv);
          inv_d  = in_inv;
          last_d = in_last;
          col_d  = '0;
          fsm_d  = in_last ? DONE : MIX;
        end else begin
          fsm_d = IDLE;
        end
      end
      MIX: begin
        st_d[32*col_q +: 32] = mix_col(st_q[32*col_q +: 32], inv_q);
        if (col_q == CW'(NB - 1) || last_q) begin
          fsm_d = DONE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
        else           fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      col_q  <= '0;
      inv_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      col_q  <= col_d;
      inv_q  <= inv_d;
      last_q <= last_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_state = st_q;

endmodule
